muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencer for the EX-stage multiply/divide resources. It latches operands at issue and drives an external pipelined multiplier (fixed latency) and an iterative divider (start/ready handshake). It produces the pipeline stall and a one-cycle HI/LO write-back.
Signed MULT is handled by magnitude conversion and sign fix-up. Flush aborts an in-flight operation cleanly.

Parameters:
MUL_LAT, 5, pipeline depth of multiplier core (edges from operand to product)
CNT_W, 4, width of latency counter; must hold MUL_LAT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
op_valid  in  1  EX holds a mult/div op; op fields held stable while stall=1
op_kind  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
a  in  32  rs operand
b  in  32  rt operand
flush  in  1  exception/flush; aborts current op
stall  out  1  freeze IF..EX
hilo_we  out  1  one-cycle HI/LO write strobe
hi  out  32  HI result
lo  out  32  LO result
mul_a  out  32  multiplier operand A (registered magnitude)
mul_b  out  32  multiplier operand B
mul_p  in  64  multiplier product
mul_sclr  out  1  multiplier synchronous clear
div_start  out  1  divider start pulse
div_signed  out  1  divider signed mode, held for op duration
div_a  out  32  dividend (registered)
div_b  out  32  divisor (registered)
div_result  in  64  {remainder, quotient}
div_ready  in  1  divider result valid (level)
div_cancel  out  1  abort divider

Behaviour:
- Reset state: IDLE. Outputs after reset: stall, hilo_we, div_start, div_cancel, mul_sclr = 0. hi, lo, mul_a/b, div_a/b = 0.
- States:
  - IDLE: on op_valid & ~flush, latch operands, sign flags and kind; go MUL (kinds 0/1) or DIV_GO (2/3).
  - MUL: counter cleared on entry and incremented each cycle. At the edge ending MUL cycle MUL_LAT+1, capture mul_p with sign fix-up into {hi,lo}; go DONE.
  - DIV_GO: div_start=1 for exactly this cycle; go DIV_WAIT.
  - DIV_WAIT: when div_ready=1, capture hi=div_result[63:32], lo=div_result[31:0]; go DONE.
  - DONE: hilo_we=1, stall=0; go IDLE unconditionally. EX advances at this edge, so the same op is never reissued.
- stall = ((IDLE & op_valid) | MUL | DIV_GO | DIV_WAIT) & ~flush. stall is combinational, so it is high in the issue cycle.
- MULT latency: stall high MUL_LAT+2 cycles; hilo_we in cycle T+MUL_LAT+2, where T is the issue cycle.
- Signed MULT: mul_a=|a|, mul_b=|b| (two's complement). The product is negated iff a[31]^b[31]. MULTU passes operands raw.
- |0x80000000| = 0x80000000, treated as unsigned magnitude; the product remains correct.
- Divide by zero: b==0 skips the divider. Go directly to DONE with hi=a, lo=0xFFFFFFFF; stall lasts the issue cycle only.
- Flush, any state: next state IDLE; stall forced 0 the same cycle; no hilo_we; hi/lo unchanged.
  - Pulse div_cancel for one cycle if in DIV_GO/DIV_WAIT.
  - Pulse mul_sclr for one cycle if in MUL.
- flush coinciding with DONE: hilo_we suppressed.
- Reset asserted mid-operation: immediate return to IDLE; all outputs to reset values; no write.
- div_ready already high in DIV_GO is ignored; it is sampled only in DIV_WAIT.
- op_valid in non-IDLE states is ignored. Op fields must not change while stall=1; this is a protocol assertion.

Decomposition:
- Shared defines header gets op_kind encodings and state encodings (IDLE, MUL, DIV_GO, DIV_WAIT, DONE). The existing EXE_*_OP defines map to op_kind in the decoder.
- One natural sub-module, muldiv_signfix: combinational abs/negate helper for the operand magnitudes and the 64-bit product fix-up.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7 -> stall 7 cycles, then hilo_we with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE; signed MULT of the same values -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV a=-7, b=2 with a model divider (ready after 33 cycles) -> div_start single pulse, div_signed=1; hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3); stall drops in DONE.
- DIVU a=5, b=0 -> no div_start; next cycle hilo_we with hi=5, lo=0xFFFFFFFF.
- flush in the 3rd MUL cycle and the 10th DIV_WAIT cycle -> stall drops the same cycle; one-cycle mul_sclr / div_cancel; no hilo_we; hi/lo retain prior values.
- Back-to-back MULT then DIVU held on op_valid -> second op issues the cycle after DONE; exactly one hilo_we per op; rst low mid-DIV_WAIT -> outputs zero asynchronously.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the EX-stage multiply/divide sequencer.
//   op_kind_e : operation encoding presented on op_kind
//   state_e   : sequencer state encoding
//   hilo_t    : {HI, LO} result payload, also the divider {remainder, quotient} layout
package muldiv_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DLEN = 2 * XLEN;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_kind_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL      = 3'd1,
        S_DIV_GO   = 3'd2,
        S_DIV_WAIT = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Divide kinds share the upper encoding bit.
    function automatic logic is_div(input op_kind_e k);
        return k[1];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling for signed multiply.
//   sgn        : operands are two's complement (MULT)
//   a, b       : raw operands
//   prod       : unsigned magnitude product from the multiplier core
//   prod_neg   : latched negate flag for the in-flight product
//   a_mag_c    : |a| when signed, else a
//   b_mag_c    : |b| when signed, else b
//   neg_c      : product must be negated (signs differ, signed op only)
//   prod_fix_c : prod, two's-complement negated when prod_neg
module muldiv_signfix
    import muldiv_ctrl_pkg::*;
(
    input  logic            sgn,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [DLEN-1:0] prod,
    input  logic            prod_neg,
    output logic [XLEN-1:0] a_mag_c,
    output logic [XLEN-1:0] b_mag_c,
    output logic            neg_c,
    output logic [DLEN-1:0] prod_fix_c
);

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    assign a_mag_c    = (sgn && a[XLEN-1]) ? XLEN'(-a) : a;
    assign b_mag_c    = (sgn && b[XLEN-1]) ? XLEN'(-b) : b;
    assign neg_c      = sgn && (a[XLEN-1] ^ b[XLEN-1]);
    assign prod_fix_c = prod_neg ? DLEN'(-prod) : prod;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer. Latches operands at issue, drives a
// fixed-latency pipelined multiplier and a start/ready iterative divider,
// raises the pipeline stall and emits a one-cycle HI/LO write-back.
//   clk, rst          : clock, asynchronous active-low reset
//   op_valid/op_kind  : mult/div op held in EX (stable while stall)
//   a, b              : rs / rt operands
//   flush             : abort current op, no write-back
//   stall             : freeze IF..EX (combinational, high in issue cycle)
//   hilo_we, hi, lo   : HI/LO write strobe and result
//   mul_*             : multiplier operands, product, synchronous clear
//   div_*             : divider operands, start, mode, result, ready, cancel
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned CNT_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [1:0]      op_kind,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            hilo_we,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic [DLEN-1:0] mul_p,
    output logic            mul_sclr,
    output logic            div_start,
    output logic            div_signed,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    input  logic [DLEN-1:0] div_result,
    input  logic            div_ready,
    output logic            div_cancel
);

    localparam int unsigned OPCHK_W = 1 + 2 + 2 * XLEN;

    state_e            state_q;
    state_e            state_d;
    op_kind_e          kind;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    hilo_t             hilo_q;
    logic              issue;
    logic              div_zero;
    logic              mul_cap;
    logic              div_cap;
    logic [XLEN-1:0]   a_mag_c;
    logic [XLEN-1:0]   b_mag_c;
    logic              neg_c;
    logic [DLEN-1:0]   prod_fix_c;

    assign kind     = op_kind_e'(op_kind);
    assign issue    = (state_q == S_IDLE) && op_valid && !flush;
    assign div_zero = (b == '0);
    // Product is valid in MUL cycle MUL_LAT+1, i.e. when the counter reads MUL_LAT.
    assign mul_cap  = (state_q == S_MUL) && (cnt_q == CNT_W'(MUL_LAT)) && !flush;
    assign div_cap  = (state_q == S_DIV_WAIT) && div_ready && !flush;

    // Magnitudes and negate flag for signed MULT; product fix-up uses the latched flag.
    muldiv_signfix u_signfix (
        .sgn        (kind == OP_MULT),
        .a          (a),
        .b          (b),
        .prod       (mul_p),
        .prod_neg   (neg_q),
        .a_mag_c    (a_mag_c),
        .b_mag_c    (b_mag_c),
        .neg_c      (neg_c),
        .prod_fix_c (prod_fix_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    if (is_div(kind)) begin
                        state_d = div_zero ? S_DONE : S_DIV_GO;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_W'(MUL_LAT)) begin
                    state_d = S_DONE;
                end
            end
            S_DIV_GO:   state_d = S_DIV_WAIT;
            S_DIV_WAIT: begin
                if (div_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Stall and write strobe must react to flush within the same cycle.
    assign stall   = rst && !flush &&
                     (((state_q == S_IDLE) && op_valid) || (state_q == S_MUL) ||
                      (state_q == S_DIV_GO) || (state_q == S_DIV_WAIT));
    assign hilo_we = rst && !flush && (state_q == S_DONE);

    assign hi = hilo_q.hi;
    assign lo = hilo_q.lo;

    // Operand latching, result capture and one-cycle control pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            hilo_q     <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            div_a      <= '0;
            div_b      <= '0;
            div_signed <= 1'b0;
            div_start  <= 1'b0;
            div_cancel <= 1'b0;
            mul_sclr   <= 1'b0;
        end else begin
            div_start  <= (state_d == S_DIV_GO);
            div_cancel <= flush && ((state_q == S_DIV_GO) || (state_q == S_DIV_WAIT));
            mul_sclr   <= flush && (state_q == S_MUL);
            cnt_q      <= (state_q == S_MUL) ? cnt_q + CNT_W'(1) : '0;
            if (state_d == S_IDLE) begin
                div_signed <= 1'b0;
            end
            if (issue) begin
                if (is_div(kind)) begin
                    div_a      <= a;
                    div_b      <= b;
                    div_signed <= (kind == OP_DIV);
                    if (div_zero) begin
                        hilo_q.hi <= a;
                        hilo_q.lo <= '1;
                    end
                end else begin
                    mul_a <= a_mag_c;
                    mul_b <= b_mag_c;
                    neg_q <= neg_c;
                end
            end
            if (mul_cap) begin
                hilo_q <= hilo_t'(prod_fix_c);
            end
            if (div_cap) begin
                hilo_q <= hilo_t'(div_result);
            end
        end
    end

    // Protocol check: EX must not change the op while it is being stalled.
    logic               stall_prev_q;
    logic [OPCHK_W-1:0] op_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_prev_q <= 1'b0;
            op_prev_q    <= '0;
        end else begin
            stall_prev_q <= stall;
            op_prev_q    <= {op_valid, op_kind, a, b};
            if (stall_prev_q) begin
                assert (op_prev_q == {op_valid, op_kind, a, b});
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a pipelined multiplier model and an
// iterative divider model (ready 33 cycles after start).
module tb_muldiv_ctrl;

    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned CNT_W   = 4;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_kind;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        mul_sclr;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [63:0] div_result;
    logic        div_ready;
    logic        div_cancel;

    int n_chk;
    int n_pass;
    int n_we;
    int n_start;
    logic sgn_at_start;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_kind    (op_kind),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .stall      (stall),
        .hilo_we    (hilo_we),
        .hi         (hi),
        .lo         (lo),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .mul_sclr   (mul_sclr),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_result (div_result),
        .div_ready  (div_ready),
        .div_cancel (div_cancel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: MUL_LAT register stages of unsigned product.
    logic [63:0] mpipe [MUL_LAT];
    assign mul_p = mpipe[MUL_LAT-1];
    always @(posedge clk) begin
        if (mul_sclr) begin
            for (int i = 0; i < MUL_LAT; i++) mpipe[i] <= '0;
        end else begin
            mpipe[0] <= 64'(mul_a) * 64'(mul_b);
            for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end

    // Divider model: {remainder, quotient}, truncating signed division.
    function automatic logic [63:0] div_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic s);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic [31:0] q;
        logic [31:0] r;
        sx = x;
        sy = y;
        if (s) begin
            q = 32'(sx / sy);
            r = 32'(sx % sy);
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    int          dcnt;
    logic [31:0] dm_a;
    logic [31:0] dm_b;
    logic        dm_s;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_ready  <= 1'b0;
            div_result <= '0;
            dcnt       <= 0;
        end else if (div_cancel) begin
            div_ready <= 1'b0;
            dcnt      <= 0;
        end else if (div_start) begin
            div_ready <= 1'b0;
            dcnt      <= 33;
            dm_a      <= div_a;
            dm_b      <= div_b;
            dm_s      <= div_signed;
        end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
        end else if (dcnt == 1) begin
            dcnt       <= 0;
            div_ready  <= 1'b1;
            div_result <= div_model(dm_a, dm_b, dm_s);
        end
    end

    // Pulse monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (hilo_we) n_we++;
        if (div_start) begin
            n_start++;
            sgn_at_start = div_signed;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Present an op and hold it until stall drops (the DONE cycle).
    task automatic run_op(input logic [1:0] k, input logic [31:0] va, input logic [31:0] vb,
                          output int ncyc);
        op_valid = 1'b1;
        op_kind  = k;
        a        = va;
        b        = vb;
        #1;
        ncyc = 0;
        while (stall && ncyc < 200) begin
            ncyc++;
            tick();
        end
    endtask

    int nc;
    int we0;
    int st0;

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        n_we     = 0;
        n_start  = 0;
        rst      = 1'b0;
        op_valid = 1'b1;
        op_kind  = 2'd0;
        a        = 32'd1;
        b        = 32'd1;
        flush    = 1'b0;

        repeat (3) tick();
        chk("reset_ctl", 64'({stall, hilo_we, div_start, div_cancel, mul_sclr, div_signed}), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_mul_ops", {mul_a, mul_b}, 64'd0);
        chk("reset_div_ops", {div_a, div_b}, 64'd0);
        op_valid = 1'b0;
        rst = 1'b1;
        tick();

        // MULT -3 * 7
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, nc);
        chk("mult_stall_cycles", 64'(nc), 64'd7);
        chk("mult_we", 64'(hilo_we), 64'd1);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_mag", {mul_a, mul_b}, {32'd3, 32'd7});
        tick();
        op_valid = 1'b0;
        #1;
        chk("mult_we_single", 64'(hilo_we), 64'd0);
        tick();

        // MULTU 0xFFFFFFFF * 2
        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, nc);
        chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        chk("multu_raw_ops", {mul_a, mul_b}, {32'hFFFF_FFFF, 32'd2});
        tick();
        // Signed MULT of the same values
        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, nc);
        chk("mult_m1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mult_m1_mag", {mul_a, mul_b}, {32'd1, 32'd2});
        tick();
        // Most negative operand
        run_op(2'd0, 32'h8000_0000, 32'd2, nc);
        chk("mult_min_hilo", {hi, lo}, 64'hFFFF_FFFF_0000_0000);
        chk("mult_min_mag", 64'(mul_a), 64'h8000_0000);
        tick();
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, nc);
        chk("mult_minmin_hilo", {hi, lo}, 64'h4000_0000_0000_0000);
        tick();
        op_valid = 1'b0;
        tick();

        // DIV -7 / 2
        st0 = n_start;
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, nc);
        chk("div_stall_cycles", 64'(nc), 64'd36);
        chk("div_we", 64'(hilo_we), 64'd1);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_start_count", 64'(n_start - st0), 64'd1);
        chk("div_signed_at_start", 64'(sgn_at_start), 64'd1);
        chk("div_ops", {div_a, div_b}, {32'hFFFF_FFF9, 32'd2});
        tick();
        op_valid = 1'b0;
        tick();

        // DIVU 5 / 0
        st0 = n_start;
        run_op(2'd3, 32'd5, 32'd0, nc);
        chk("div0_stall_cycles", 64'(nc), 64'd1);
        chk("div0_we", 64'(hilo_we), 64'd1);
        chk("div0_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        tick();
        op_valid = 1'b0;
        #1;
        chk("div0_no_start", 64'(n_start - st0), 64'd0);
        tick();

        // Flush in the 3rd MUL cycle
        we0 = n_we;
        op_valid = 1'b1;
        op_kind  = 2'd0;
        a        = 32'd3;
        b        = 32'd4;
        repeat (3) tick();
        flush = 1'b1;
        #1;
        chk("mflush_stall", 64'({stall, hilo_we}), 64'd0);
        tick();
        flush    = 1'b0;
        op_valid = 1'b0;
        #1;
        chk("mflush_sclr", 64'({mul_sclr, div_cancel}), 64'b10);
        tick();
        chk("mflush_sclr_once", 64'(mul_sclr), 64'd0);
        repeat (10) tick();
        chk("mflush_hilo_kept", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        chk("mflush_no_we", 64'(n_we - we0), 64'd0);

        // Flush in the 10th DIV_WAIT cycle
        op_valid = 1'b1;
        op_kind  = 2'd2;
        a        = 32'd100;
        b        = 32'd7;
        repeat (11) tick();
        flush = 1'b1;
        #1;
        chk("dflush_stall", 64'({stall, hilo_we}), 64'd0);
        tick();
        flush    = 1'b0;
        op_valid = 1'b0;
        #1;
        chk("dflush_cancel", 64'({div_cancel, mul_sclr}), 64'b10);
        tick();
        chk("dflush_cancel_once", 64'(div_cancel), 64'd0);
        repeat (40) tick();
        chk("dflush_hilo_kept", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        chk("dflush_no_we", 64'(n_we - we0), 64'd0);

        // Flush coinciding with DONE suppresses the write strobe
        run_op(2'd1, 32'd2, 32'd3, nc);
        flush = 1'b1;
        #1;
        chk("done_flush_we", 64'(hilo_we), 64'd0);
        tick();
        flush    = 1'b0;
        op_valid = 1'b0;
        tick();
        chk("done_flush_no_we", 64'(n_we - we0), 64'd0);

        // Back-to-back MULT then DIVU, op_valid held across
        we0 = n_we;
        run_op(2'd0, 32'd6, 32'd7, nc);
        chk("b2b_mult_hilo", {hi, lo}, {32'd0, 32'd42});
        tick();
        op_kind = 2'd3;
        a       = 32'd100;
        b       = 32'd7;
        #1;
        chk("b2b_second_issue", 64'(stall), 64'd1);
        run_op(2'd3, 32'd100, 32'd7, nc);
        chk("b2b_divu_hilo", {hi, lo}, {32'd2, 32'd14});
        tick();
        op_valid = 1'b0;
        tick();
        chk("b2b_we_count", 64'(n_we - we0), 64'd2);

        // Reset asserted mid-DIV_WAIT
        op_valid = 1'b1;
        op_kind  = 2'd2;
        a        = 32'd50;
        b        = 32'd5;
        repeat (6) tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_ctl", 64'({stall, hilo_we, div_start, div_cancel, mul_sclr, div_signed}), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_ops", {div_a, div_b}, 64'd0);
        chk("rst_mid_mul_ops", {mul_a, mul_b}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
